// File: rtl/video_timing_gen.sv
// Pixel-clock video timing generator (HS/VS/DE, coordinates, frame strobe) held idle until PLL lock is stable.
// Define VTG_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module video_timing_gen #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int LOCK_WAIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_lock,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start,
  output logic        timing_valid
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int LW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_WAIT - 1);

  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic {WAIT_LOCK, RUN} state_t;

  state_t        state_q, state_d;
  logic          lock_m, lock_s;
  logic [LW-1:0] lock_cnt, lock_d;
  logic [11:0]   h_cnt, h_d, v_cnt, v_d;
  logic          de_c, hs_act, vs_act;

  // pll_lock is asynchronous to clk; two flops before any logic sees it.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_LOCK;
      lock_cnt <= '0;
      h_cnt    <= '0;
      v_cnt    <= '0;
    end else begin
      state_q  <= state_d;
      lock_cnt <= lock_d;
      h_cnt    <= h_d;
      v_cnt    <= v_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_cnt;
    h_d     = h_cnt;
    v_d     = v_cnt;
    unique case (state_q)
      WAIT_LOCK: begin
        h_d = '0;
        v_d = '0;
        if (!lock_s) begin
          lock_d = '0;
        end else if (lock_cnt == LOCK_LAST) begin
          state_d = RUN;
          lock_d  = '0;
        end else begin
          lock_d = lock_cnt + LW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          lock_d  = '0;
          h_d     = '0;
          v_d     = '0;
        end else if (h_cnt == H_LAST) begin
          h_d = '0;
          v_d = (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end else begin
          h_d = h_cnt + 12'd1;
        end
      end
    endcase
  end

  assign de_c   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_act = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  // v_cnt only moves on the h_cnt wrap, so vs changes only with registered h_cnt=0.
  assign vs_act = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs           <= ~HS_POL;
      vs           <= ~VS_POL;
      de           <= 1'b0;
      x            <= '0;
      y            <= '0;
      frame_start  <= 1'b0;
      timing_valid <= 1'b0;
    end else if (state_q == RUN) begin
      hs           <= hs_act ~^ HS_POL;
      vs           <= vs_act ~^ VS_POL;
      de           <= de_c;
      x            <= de_c ? h_cnt : 12'd0;
      y            <= de_c ? v_cnt : 12'd0;
      frame_start  <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
      timing_valid <= 1'b1;
    end else begin
      hs           <= ~HS_POL;
      vs           <= ~VS_POL;
      de           <= 1'b0;
      x            <= '0;
      y            <= '0;
      frame_start  <= 1'b0;
      timing_valid <= 1'b0;
    end
  end

`ifdef VTG_FRAME_CNT_EN
  // Advances at the end of the frame_start cycle, so frame N's strobe shows frame_cnt=N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (state_d == WAIT_LOCK) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: small-geometry DUTs (both polarities) plus a default 720p DUT.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic pll_lock;

  logic s_hs, s_vs, s_de, s_fs, s_tv;
  logic p_hs, p_vs, p_de, p_fs, p_tv;
  logic h_hs, h_vs, h_de, h_fs, h_tv;
  logic [11:0] s_x, s_y, p_x, p_y, h_x, h_y;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0] s_fc, p_fc, h_fc;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int pos;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_WAIT(4)
  ) dut_s (
    .clk(clk), .rst(rst), .pll_lock(pll_lock),
    .hs(s_hs), .vs(s_vs), .de(s_de), .x(s_x), .y(s_y),
    .frame_start(s_fs), .timing_valid(s_tv)
`ifdef VTG_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_WAIT(4)
  ) dut_p (
    .clk(clk), .rst(rst), .pll_lock(pll_lock),
    .hs(p_hs), .vs(p_vs), .de(p_de), .x(p_x), .y(p_y),
    .frame_start(p_fs), .timing_valid(p_tv)
`ifdef VTG_FRAME_CNT_EN
    , .frame_cnt(p_fc)
`endif
  );

  video_timing_gen dut_h (
    .clk(clk), .rst(rst), .pll_lock(pll_lock),
    .hs(h_hs), .vs(h_vs), .de(h_de), .x(h_x), .y(h_y),
    .frame_start(h_fs), .timing_valid(h_tv)
`ifdef VTG_FRAME_CNT_EN
    , .frame_cnt(h_fc)
`endif
  );

  // Packed view {de, hs, vs, frame_start, timing_valid, x, y}
  logic [28:0] s_vec, p_vec, h_vec;
  assign s_vec = {s_de, s_hs, s_vs, s_fs, s_tv, s_x, s_y};
  assign p_vec = {p_de, p_hs, p_vs, p_fs, p_tv, p_x, p_y};
  assign h_vec = {h_de, h_hs, h_vs, h_fs, h_tv, h_x, h_y};

  function automatic logic [28:0] model(int h, int v, int ha, int hfp, int hsw,
                                        int va, int vfp, int vsw, bit hpol, bit vpol);
    logic d, hsa, vsa;
    d   = (h < ha) && (v < va);
    hsa = (h >= ha + hfp) && (h < ha + hfp + hsw);
    vsa = (v >= va + vfp) && (v < va + vfp + vsw);
    return {d, hpol ? hsa : !hsa, vpol ? vsa : !vsa, (h == 0) && (v == 0), 1'b1,
            d ? 12'(h) : 12'd0, d ? 12'(v) : 12'd0};
  endfunction

  function automatic logic [28:0] small_model(int p, bit pol);
    return model(p % 14, (p / 14) % 7, 8, 2, 2, 4, 1, 1, pol, pol);
  endfunction

  function automatic logic [28:0] idle(bit hpol, bit vpol);
    return {1'b0, !hpol, !vpol, 1'b0, 1'b0, 24'd0};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Raise pll_lock and count edges until the small DUT shows its first de (bounded).
  task automatic lock_and_wait(output int n);
    pll_lock = 1'b1;
    n = 0;
    while (!s_de && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (s_vec !== idle(1'b1, 1'b1)) begin
      tests_failed++; $display("FAIL reset_s got=%h exp=%h", s_vec, idle(1'b1, 1'b1));
    end
    tests_run++;
    if (p_vec !== idle(1'b0, 1'b0)) begin
      tests_failed++; $display("FAIL reset_p got=%h exp=%h", p_vec, idle(1'b0, 1'b0));
    end
    tests_run++;
    if (h_vec !== idle(1'b1, 1'b1)) begin
      tests_failed++; $display("FAIL reset_h got=%h exp=%h", h_vec, idle(1'b1, 1'b1));
    end
`ifdef VTG_FRAME_CNT_EN
    tests_run++;
    if (s_fc !== 16'd0) begin
      tests_failed++; $display("FAIL reset_fc got=%0d exp=0", s_fc);
    end
`endif
    rst = 1'b0;
    repeat (3) step();
    tests_run++;
    if (s_vec !== idle(1'b1, 1'b1)) begin
      tests_failed++; $display("FAIL idle_no_lock got=%h exp=%h", s_vec, idle(1'b1, 1'b1));
    end
  endtask

  task automatic test_lock_latency();
    int n;
    lock_and_wait(n);
    tests_run++;
    if (n != 7) begin
      tests_failed++; $display("FAIL first_de_latency got=%0d exp=7", n);
    end
    pos = 0;
  endtask

  // Two full frames from the first active pixel against the model.
  task automatic test_frame();
    for (int i = 0; i < 196; i++) begin
      if (i > 0) begin
        step();
        pos++;
      end
      tests_run++;
      if (s_vec !== small_model(pos, 1'b1)) begin
        tests_failed++; $display("FAIL frame pos=%0d got=%h exp=%h", pos, s_vec, small_model(pos, 1'b1));
      end
`ifdef VTG_FRAME_CNT_EN
      tests_run++;
      if (s_fc !== 16'((pos % 98 == 0) ? pos / 98 : pos / 98 + 1)) begin
        tests_failed++; $display("FAIL frame_cnt pos=%0d got=%0d", pos, s_fc);
      end
`endif
    end
  endtask

  task automatic test_polarity();
    for (int i = 0; i < 98; i++) begin
      step();
      pos++;
      tests_run++;
      if (p_vec !== small_model(pos, 1'b0)) begin
        tests_failed++; $display("FAIL polarity pos=%0d got=%h exp=%h", pos, p_vec, small_model(pos, 1'b0));
      end
    end
  endtask

  task automatic test_drop_mid_line();
    int n;
    n = 0;
    while (!(s_de && s_x == 12'd3) && n < 30) begin
      step();
      n++;
    end
    tests_run++;
    if (n >= 30) begin
      tests_failed++; $display("FAIL drop_find_x3 got=timeout exp=x3");
    end
    pll_lock = 1'b0;
    repeat (3) step();
    tests_run++;
    if ({s_de, s_tv, s_x} !== {1'b1, 1'b1, 12'd6}) begin
      tests_failed++; $display("FAIL drop_last_active got=%h exp=%h", {s_de, s_tv, s_x}, {1'b1, 1'b1, 12'd6});
    end
    step();
    tests_run++;
    if (s_vec !== idle(1'b1, 1'b1)) begin
      tests_failed++; $display("FAIL drop_idle got=%h exp=%h", s_vec, idle(1'b1, 1'b1));
    end
    tests_run++;
    if (p_vec !== idle(1'b0, 1'b0)) begin
      tests_failed++; $display("FAIL drop_idle_p got=%h exp=%h", p_vec, idle(1'b0, 1'b0));
    end
`ifdef VTG_FRAME_CNT_EN
    tests_run++;
    if (s_fc !== 16'd0) begin
      tests_failed++; $display("FAIL drop_fc got=%0d exp=0", s_fc);
    end
`endif
    lock_and_wait(n);
    tests_run++;
    if (n != 7) begin
      tests_failed++; $display("FAIL relock_latency got=%0d exp=7", n);
    end
    tests_run++;
    if (s_vec !== small_model(0, 1'b1)) begin
      tests_failed++; $display("FAIL relock_origin got=%h exp=%h", s_vec, small_model(0, 1'b1));
    end
  endtask

  task automatic test_lock_glitch();
    int n;
    int bad;
    pll_lock = 1'b0;
    repeat (8) step();
    tests_run++;
    if (s_vec !== idle(1'b1, 1'b1)) begin
      tests_failed++; $display("FAIL glitch_pre_idle got=%h exp=%h", s_vec, idle(1'b1, 1'b1));
    end
    bad = 0;
    pll_lock = 1'b1;
    repeat (3) begin
      step();
      if (s_tv || s_de) bad++;
    end
    pll_lock = 1'b0;
    repeat (20) begin
      step();
      if (s_tv || s_de) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL glitch_no_run got=%0d active samples exp=0", bad);
    end
    lock_and_wait(n);
    tests_run++;
    if (n != 7) begin
      tests_failed++; $display("FAIL glitch_relock_latency got=%0d exp=7", n);
    end
  endtask

  // Default 720p geometry: lock latency plus two full lines.
  task automatic test_hd();
    int n;
    pll_lock = 1'b0;
    repeat (4) step();
    pll_lock = 1'b1;
    n = 0;
    while (!h_de && n < 1200) begin
      step();
      n++;
    end
    tests_run++;
    if (n != 1027) begin
      tests_failed++; $display("FAIL hd_latency got=%0d exp=1027", n);
    end
    for (int i = 0; i < 3300; i++) begin
      if (i > 0) step();
      tests_run++;
      if (h_vec !== model(i % 1650, i / 1650, 1280, 110, 40, 720, 5, 5, 1'b1, 1'b1)) begin
        tests_failed++;
        $display("FAIL hd_line pos=%0d got=%h exp=%h", i, h_vec,
                 model(i % 1650, i / 1650, 1280, 110, 40, 720, 5, 5, 1'b1, 1'b1));
      end
`ifdef VTG_FRAME_CNT_EN
      tests_run++;
      if (h_fc !== ((i == 0) ? 16'd0 : 16'd1)) begin
        tests_failed++; $display("FAIL hd_frame_cnt pos=%0d got=%0d", i, h_fc);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_lock_latency();
    test_frame();
    test_polarity();
    test_drop_mid_line();
    test_lock_glitch();
    test_hd();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
